// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data-memory responder.
package data_mem_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_e;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;
    localparam int WAIT_MAX   = 15;
    localparam int CNT_W      = 16;
endpackage

// File: rtl/dm_storage_ram.sv
// DEPTH x DATA_W storage: synchronous write, registered read, array never reset.
module dm_storage_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] q
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr[IDX_W-1:0]] <= wdata;
        q <= mem[raddr[IDX_W-1:0]];
    end
endmodule

// File: rtl/data_mem_responder.sv
// Four-phase req/ack data-memory responder with WAIT_CYCLES wait states.
// Optional DATA_MEM_ACCESS_COUNT_EN adds saturating rd_count/wr_count outputs.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              busy
`ifdef DATA_MEM_ACCESS_COUNT_EN
    ,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count
`endif
);
    state_e            state, nxt;
    logic [3:0]        cnt;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              in_range;
    logic              access;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_raddr;
    logic [DATA_W-1:0] ram_q;

    assign in_range  = {1'b0, lat_addr} < (ADDR_W+1)'(DEPTH);
    assign access    = (state == ACCESS) && req && (cnt == 4'd0);
    assign ram_we    = access && lat_we && in_range;
    assign busy      = (state != IDLE);
    // Read the live address while idle so the registered RAM output is
    // already valid on the first ACCESS cycle (needed for WAIT_CYCLES=0).
    assign ram_raddr = (state == IDLE) ? addr : lat_addr;

    dm_storage_ram #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(lat_addr),
        .wdata(lat_wdata),
        .raddr(ram_raddr),
        .q    (ram_q)
    );

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (req) nxt = ACCESS;
            ACCESS:  if (!req) nxt = IDLE;
                     else if (cnt == 4'd0) nxt = ACK;
            ACK:     if (!req) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            ack       <= 1'b0;
            rdata     <= '0;
            err       <= 1'b0;
        end else begin
            state <= nxt;
            case (state)
                IDLE: if (req) begin
                    lat_we    <= we;
                    lat_addr  <= addr;
                    lat_wdata <= wdata;
                    cnt       <= 4'(WAIT_CYCLES);
                end
                ACCESS: begin
                    if (req && cnt != 4'd0)
                        cnt <= cnt - 4'd1;
                    if (access) begin
                        ack   <= 1'b1;
                        err   <= ~in_range;
                        rdata <= lat_we ? lat_wdata : (in_range ? ram_q : '0);
                    end
                end
                ACK: if (!req) begin
                    ack <= 1'b0;
                    err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef DATA_MEM_ACCESS_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (access && in_range) begin
            if (lat_we && wr_count != '1)
                wr_count <= wr_count + 1'b1;
            if (!lat_we && rd_count != '1)
                rd_count <= rd_count + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: three responders (WAIT 1/0/3) sharing stimulus buses, separate req lines.
module tb_data_mem_responder;
    logic       clk, reset;
    logic       req   [3];
    logic       we;
    logic [7:0] addr, wdata;
    logic       ack   [3];
    logic       err   [3];
    logic       busy  [3];
    logic [7:0] rdata [3];
`ifdef DATA_MEM_ACCESS_COUNT_EN
    logic [15:0] rd_count [3];
    logic [15:0] wr_count [3];
`endif

    int n_chk  = 0;
    int n_pass = 0;

    data_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(128), .WAIT_CYCLES(1)) u_dut0 (
        .clk(clk), .reset(reset), .req(req[0]), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack[0]), .rdata(rdata[0]), .err(err[0]), .busy(busy[0])
`ifdef DATA_MEM_ACCESS_COUNT_EN
        , .rd_count(rd_count[0]), .wr_count(wr_count[0])
`endif
    );
    data_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_CYCLES(0)) u_dut1 (
        .clk(clk), .reset(reset), .req(req[1]), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack[1]), .rdata(rdata[1]), .err(err[1]), .busy(busy[1])
`ifdef DATA_MEM_ACCESS_COUNT_EN
        , .rd_count(rd_count[1]), .wr_count(wr_count[1])
`endif
    );
    data_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_CYCLES(3)) u_dut2 (
        .clk(clk), .reset(reset), .req(req[2]), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack[2]), .rdata(rdata[2]), .err(err[2]), .busy(busy[2])
`ifdef DATA_MEM_ACCESS_COUNT_EN
        , .rd_count(rd_count[2]), .wr_count(wr_count[2])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Full handshake on responder d; hold = extra ACK cycles with garbled inputs.
    task automatic txn(input int d, input logic w, input logic [7:0] a, input logic [7:0] wd,
                       input int hold, output logic [7:0] rd, output logic e, output int lat);
        @(negedge clk);
        we = w; addr = a; wdata = wd; req[d] = 1'b1;
        @(negedge clk);
        lat = 0;
        while (!ack[d] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!ack[d]) chk("ack_timeout", 32'(ack[d]), 32'd1);
        rd = rdata[d];
        e  = err[d];
        for (int i = 0; i < hold; i++) begin
            we = ~w; addr = ~a; wdata = ~wd;
            @(negedge clk);
            chk("hold_ack", 32'(ack[d]), 32'd1);
            chk("hold_rdata", 32'(rdata[d]), 32'(rd));
        end
        req[d] = 1'b0;
        @(negedge clk);
        chk("ack_drop", 32'(ack[d]), 32'd0);
        chk("busy_drop", 32'(busy[d]), 32'd0);
    endtask

    logic [7:0] rd;
    logic       e;
    int         lat;
    logic       seen;

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 3; i++) req[i] = 1'b0;
        we = 1'b0; addr = 8'h00; wdata = 8'h00;
        #12;
        chk("rst_ack",   32'(ack[0]),   32'd0);
        chk("rst_rdata", 32'(rdata[0]), 32'd0);
        chk("rst_err",   32'(err[0]),   32'd0);
        chk("rst_busy",  32'(busy[0]),  32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Write then read, WAIT_CYCLES=1
        txn(0, 1'b1, 8'h10, 8'hA5, 2, rd, e, lat);
        chk("w1_lat", 32'(lat), 32'd2);
        chk("w1_rdata", 32'(rd), 32'hA5);
        chk("w1_err", 32'(e), 32'd0);
        chk("rdata_keep", 32'(rdata[0]), 32'hA5);
        txn(0, 1'b0, 8'h10, 8'h00, 0, rd, e, lat);
        chk("r1_lat", 32'(lat), 32'd2);
        chk("r1_rdata", 32'(rd), 32'hA5);

        // WAIT_CYCLES=0 read after write
        txn(1, 1'b1, 8'h20, 8'h3C, 0, rd, e, lat);
        chk("w0_lat", 32'(lat), 32'd1);
        txn(1, 1'b0, 8'h20, 8'h00, 0, rd, e, lat);
        chk("r0_lat", 32'(lat), 32'd1);
        chk("r0_rdata", 32'(rd), 32'h3C);

        // Abort with WAIT_CYCLES=3
        txn(2, 1'b1, 8'h05, 8'h11, 0, rd, e, lat);
        chk("w3_lat", 32'(lat), 32'd4);
        @(negedge clk);
        we = 1'b1; addr = 8'h05; wdata = 8'hFF; req[2] = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy[2]), 32'd1);
        @(negedge clk);
        req[2] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen |= ack[2];
        end
        chk("abort_no_ack", 32'(seen), 32'd0);
        chk("abort_idle", 32'(busy[2]), 32'd0);
        txn(2, 1'b0, 8'h05, 8'h00, 0, rd, e, lat);
        chk("abort_keep", 32'(rd), 32'h11);

        // Out-of-range, DEPTH=128
        txn(0, 1'b1, 8'h00, 8'h5A, 0, rd, e, lat);
        txn(0, 1'b1, 8'h80, 8'h77, 0, rd, e, lat);
        chk("oor_w_err", 32'(e), 32'd1);
        txn(0, 1'b0, 8'h80, 8'h00, 0, rd, e, lat);
        chk("oor_r_rdata", 32'(rd), 32'h00);
        chk("oor_r_err", 32'(e), 32'd1);
        txn(0, 1'b0, 8'h00, 8'h00, 0, rd, e, lat);
        chk("oor_mem0", 32'(rd), 32'h5A);
        chk("oor_mem0_err", 32'(e), 32'd0);

        // Reset in ACCESS during a write
        txn(0, 1'b1, 8'h40, 8'hC3, 0, rd, e, lat);
        @(negedge clk);
        we = 1'b1; addr = 8'h40; wdata = 8'h99; req[0] = 1'b1;
        @(negedge clk);
        chk("mid_busy", 32'(busy[0]), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_ack", 32'(ack[0]), 32'd0);
        chk("mid_rst_busy", 32'(busy[0]), 32'd0);
        req[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        txn(0, 1'b0, 8'h40, 8'h00, 0, rd, e, lat);
        chk("mid_old_data", 32'(rd), 32'hC3);

        // Reset and req together: reset wins
        @(negedge clk);
        reset = 1'b1; we = 1'b0; addr = 8'h20; req[1] = 1'b1;
        @(negedge clk);
        chk("rst_req_busy", 32'(busy[1]), 32'd0);
        req[1] = 1'b0;
        reset = 1'b0;
        txn(1, 1'b0, 8'h20, 8'h00, 0, rd, e, lat);
        chk("rst_keeps_mem", 32'(rd), 32'h3C);

`ifdef DATA_MEM_ACCESS_COUNT_EN
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        txn(0, 1'b1, 8'h01, 8'h01, 0, rd, e, lat);
        txn(0, 1'b1, 8'h02, 8'h02, 0, rd, e, lat);
        txn(0, 1'b1, 8'h03, 8'h03, 0, rd, e, lat);
        txn(0, 1'b0, 8'h01, 8'h00, 0, rd, e, lat);
        txn(0, 1'b0, 8'h02, 8'h00, 0, rd, e, lat);
        txn(0, 1'b1, 8'h90, 8'hEE, 0, rd, e, lat);
        @(negedge clk);
        we = 1'b1; addr = 8'h04; wdata = 8'h04; req[0] = 1'b1;
        @(negedge clk);
        req[0] = 1'b0;
        repeat (4) @(negedge clk);
        chk("cnt_wr", 32'(wr_count[0]), 32'd3);
        chk("cnt_rd", 32'(rd_count[0]), 32'd2);
        reset = 1'b1;
        #1;
        chk("cnt_wr_rst", 32'(wr_count[0]), 32'd0);
        chk("cnt_rd_rst", 32'(rd_count[0]), 32'd0);
        @(negedge clk);
        reset = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
